// File: rtl/field_deserializer.sv
// Purpose: LSB-first serial-to-parallel field capture with USB bit-unstuffing (up to 64 data bits).
// Latency: done / stuff_err are registered, one cycle after the bit_valid cycle that caused them.
// Backpressure: none; bit_valid may have arbitrary gaps, and the block never stalls upstream.
module field_deserializer #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [6:0]       len,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             done,
    output logic             stuff_err,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [6:0]  count;      // data bits stored so far
    logic [2:0]  ones;       // run of consecutive 1 data bits since last stuff/0
    logic [6:0]  len_q;      // effective field length, 1..64

    logic [6:0]  len_eff;
    logic        data_bit;
    logic        stuff_slot;
    logic        stuff_viol;
    logic        field_end;

    // Decode the current input cycle: normalize len, classify the incoming bit.
    always_comb begin
        len_eff    = ((len == 7'd0) || (len > 7'd64)) ? 7'd64 : len;
        data_bit   = (state == RECV) && bit_valid && (ones != 3'd6);
        stuff_slot = (state == RECV) && bit_valid && (ones == 3'd6);
        stuff_viol = stuff_slot && bit_in;
        field_end  = data_bit && ((count + 7'd1) == len_q);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: clear beats start, start beats bit handling.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!clear && start) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (clear) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = RECV;
                end else if (field_end || stuff_viol) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy = (state == RECV);
    end

    // Datapath: field assembly, run tracking, and registered completion/error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            done      <= 1'b0;
            stuff_err <= 1'b0;
            count     <= 7'd0;
            ones      <= 3'd0;
            len_q     <= 7'd64;
        end else begin
            done      <= 1'b0;
            stuff_err <= 1'b0;
            if (clear) begin
                // data_out deliberately kept: an aborted field leaves its partial value visible
                count <= 7'd0;
                ones  <= 3'd0;
            end else if (start) begin
                len_q    <= len_eff;
                data_out <= '0;
                count    <= 7'd0;
                ones     <= 3'd0;
            end else if (data_bit) begin
                data_out[count[5:0]] <= bit_in;
                count                <= count + 7'd1;
                ones                 <= bit_in ? (ones + 3'd1) : 3'd0;
                done                 <= field_end;
            end else if (stuff_slot) begin
                // A stuffed 0 is dropped; a 1 here is a stuffing violation
                ones      <= 3'd0;
                stuff_err <= bit_in;
            end
        end
    end

endmodule

// File: tb/tb_field_deserializer.sv
// Bench for field_deserializer: directed vectors, a queue-based reference model and per-cycle comparison.
// The model works on the list of received data bits rather than counters.
// Literal expectations pin both the model and the DUT at key points of each scenario.
module tb_field_deserializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [6:0]  len;
    logic        bit_in;
    logic        bit_valid;
    logic [63:0] data_out;
    logic        done;
    logic        stuff_err;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    int done_seen = 0;
    int err_seen = 0;

    always #5 clock = ~clock;

    field_deserializer #(.WIDTH(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .start     (start),
        .len       (len),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .done      (done),
        .stuff_err (stuff_err),
        .busy      (busy)
    );

    // Reference model: the field is the list of data bits received since start.
    logic        m_active = 1'b0;
    int          m_len = 64;
    logic        m_bits[$];
    int          m_stuff_at = 0;   // list position where the last stuffed 0 was dropped
    logic [63:0] e_data = '0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;

    // Number of trailing 1 data bits received since the last dropped stuff bit.
    function automatic int run_ones();
        int r = 0;
        for (int i = m_bits.size() - 1; i >= m_stuff_at; i--) begin
            if (m_bits[i]) r++;
            else break;
        end
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active   = 1'b0;
            m_bits.delete();
            m_stuff_at = 0;
            m_len      = 64;
            e_data     = '0;
            e_done     = 1'b0;
            e_err      = 1'b0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (clear) begin
                m_active = 1'b0;
            end else if (start) begin
                m_active   = 1'b1;
                m_bits.delete();
                m_stuff_at = 0;
                m_len      = ((len == 7'd0) || (len > 7'd64)) ? 64 : int'(len);
                e_data     = '0;
            end else if (m_active && bit_valid) begin
                if (run_ones() >= 6) begin
                    if (bit_in) begin
                        e_err    = 1'b1;
                        m_active = 1'b0;
                    end else begin
                        m_stuff_at = m_bits.size();
                    end
                end else begin
                    e_data[m_bits.size()] = bit_in;
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == m_len) begin
                        e_done   = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic cycle_check();
        check("cyc_data_out", data_out, e_data);
        check("cyc_done", {63'd0, done}, {63'd0, e_done});
        check("cyc_stuff_err", {63'd0, stuff_err}, {63'd0, e_err});
        check("cyc_busy", {63'd0, busy}, {63'd0, m_active});
        check("cyc_exclusive", {63'd0, done & stuff_err}, 64'd0);
        if (done === 1'b1) done_seen++;
        if (stuff_err === 1'b1) err_seen++;
    endtask

    // One clock cycle: compare on the falling edge, then drive inputs just after the rising edge.
    task automatic step(input logic st, input logic [6:0] ln, input logic v, input logic b, input logic cl);
        @(negedge clock);
        cycle_check();
        @(posedge clock);
        #1;
        start     = st;
        len       = ln;
        bit_valid = v;
        bit_in    = b;
        clear     = cl;
    endtask

    task automatic idle();
        step(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic begin_field(input logic [6:0] ln);
        step(1'b1, ln, 1'b0, 1'b0, 1'b0);
    endtask

    // Send n serial bits, LSB of pat first, on consecutive cycles.
    task automatic send(input logic [63:0] pat, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, 1'b1, pat[i], 1'b0);
    endtask

    initial begin
        int d0;
        int e0;
        reset = 1'b0; clear = 1'b0; start = 1'b0; len = 7'd0; bit_in = 1'b0; bit_valid = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_data_out", data_out, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        idle();
        idle();
        reset = 1'b0;
        idle();

        // 1: short field
        d0 = done_seen; e0 = err_seen;
        begin_field(7'd8);
        idle();
        check("t1_busy_after_start", {63'd0, busy}, 64'd1);
        send(64'h0D, 8);
        idle();
        check("t1_done", {63'd0, done}, 64'd1);
        check("t1_data", data_out, 64'h0D);
        check("t1_busy_low", {63'd0, busy}, 64'd0);
        idle();
        check("t1_done_count", 64'(done_seen - d0), 64'd1);

        // 2: stuffing (7th serial bit is a dropped 0)
        d0 = done_seen;
        begin_field(7'd8);
        send(64'h0BF, 9);
        idle();
        check("t2_done", {63'd0, done}, 64'd1);
        check("t2_data", data_out, 64'h7F);
        idle();
        check("t2_no_stuff_err", 64'(err_seen - e0), 64'd0);
        check("t2_done_count", 64'(done_seen - d0), 64'd1);

        // 3: stuff error
        d0 = done_seen;
        begin_field(7'd16);
        send(64'h7F, 7);
        idle();
        check("t3_stuff_err", {63'd0, stuff_err}, 64'd1);
        check("t3_busy", {63'd0, busy}, 64'd0);
        check("t3_data", data_out, 64'h3F);
        idle();
        idle();
        check("t3_no_done", 64'(done_seen - d0), 64'd0);

        // 4: full width via len=0 with gaps
        d0 = done_seen;
        begin_field(7'd0);
        for (int g = 0; g < 8; g++) begin
            send(64'h55, 8);
            idle(); idle(); idle();
        end
        check("t4_data", data_out, 64'h5555_5555_5555_5555);
        check("t4_done_count", 64'(done_seen - d0), 64'd1);

        // len above 64 also means 64: 63 bits leave it unfinished
        d0 = done_seen;
        begin_field(7'd100);
        send(64'h0, 63);
        idle();
        check("t4b_busy_at_63", {63'd0, busy}, 64'd1);
        send(64'h1, 1);
        idle();
        check("t4b_done", {63'd0, done}, 64'd1);
        check("t4b_data", data_out, 64'h8000_0000_0000_0000);

        // len=1 boundary
        begin_field(7'd1);
        send(64'h1, 1);
        idle();
        check("tlen1_done", {63'd0, done}, 64'd1);
        check("tlen1_data", data_out, 64'h1);

        // 5: asynchronous reset mid-field
        begin_field(7'd16);
        send(64'h16, 5);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_data", data_out, 64'd0);
        check("t5_rst_busy", {63'd0, busy}, 64'd0);
        idle();
        reset = 1'b0;
        d0 = done_seen;
        begin_field(7'd4);
        send(64'h4, 4);
        idle();
        check("t5_done", {63'd0, done}, 64'd1);
        check("t5_data", data_out, 64'h4);

        // 6: restart while receiving
        idle();
        d0 = done_seen;
        begin_field(7'd8);
        send(64'h7, 3);
        begin_field(7'd2);
        send(64'h3, 2);
        idle();
        idle();
        check("t6_data", data_out, 64'h3);
        check("t6_done_count", 64'(done_seen - d0), 64'd1);

        // 6b: clear during RECV (together with start: clear wins)
        d0 = done_seen;
        begin_field(7'd8);
        send(64'h1, 2);
        step(1'b1, 7'd8, 1'b1, 1'b1, 1'b1);
        idle();
        check("t6b_busy", {63'd0, busy}, 64'd0);
        send(64'h7, 8);
        idle();
        check("t6b_data_kept", data_out, 64'h1);
        check("t6b_no_done", 64'(done_seen - d0), 64'd0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/field_deserializer.md
Name: field_deserializer

Overview:
- Receive-side counterpart of the transmit bit-order reversal used by the USB packet path.
- Accepts a serial bitstream LSB-first, one bit per `bit_valid` strobe, removes USB bit-stuffing, and assembles up to 64 data bits into a parallel word.
- The first received data bit lands in `data_out[0]`.
- Sits between the NRZI decoder and the packet field checkers (PID/ADDR/ENDP/CRC/DATA).

Parameters:
- WIDTH, 64, maximum field width in bits; fixed at 64 for this design.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; returns block to IDLE, no done.
- start  input  1  one-cycle pulse; begins a new field capture.
- len  input  7  number of data bits to collect; sampled on start.
- bit_in  input  1  serial data bit, valid when bit_valid=1.
- bit_valid  input  1  qualifies bit_in; may have arbitrary gaps.
- data_out  output  64  assembled field; bit k = k-th data bit received.
- done  output  1  one-cycle pulse; data_out complete.
- stuff_err  output  1  one-cycle pulse; stuffing violation detected.
- busy  output  1  high while in RECV.

Behaviour:
- Reset (async, any state) drives the following, then state=IDLE:
  - data_out=0, done=0, stuff_err=0, busy=0.
  - bit count=0, ones run=0, latched len=64.
- FSM states: IDLE, RECV.
- IDLE:
  - bit_valid ignored.
  - start → RECV; latch len, clear data_out to 0, count=0, ones=0.
  - busy rises the cycle after start.
- Length rule: len in 1..64 used as-is; len=0 or len>64 treated as 64.
- RECV, cycle with bit_valid=1 and ones<6 (data bit):
  - data_out[count] <= bit_in; count <= count+1.
  - ones <= bit_in ? ones+1 : 0.
- RECV, cycle with bit_valid=1 and ones==6 (stuff bit):
  - bit_in=0: bit dropped, ones <= 0, count unchanged.
  - bit_in=1: stuff_err pulses next cycle; return to IDLE; no done; data_out holds the partial value.
- Completion:
  - When a data bit brings count to the latched len, done pulses the following cycle and state → IDLE.
  - A stuff bit owed after the final data bit is not consumed; upstream discards it.
- Latency: done/stuff_err are registered, asserted exactly one cycle after the bit_valid cycle that caused them.
- data_out:
  - Bits at positions ≥ len remain 0.
  - Value holds stable from done until the next start, reset, or clear.
- Cycles with bit_valid=0 in RECV: no state change.
- start while in RECV: aborts the current field and restarts (same actions as start in IDLE); no done or stuff_err for the aborted field.
- clear:
  - Has priority over start and bit_valid.
  - Forces IDLE, busy=0, count=0, ones=0; data_out unchanged.
- done and stuff_err are never asserted in the same cycle.

Test Plan:
1. Short field:
   - Stimulus: reset, start len=8, bits 1,0,1,1,0,0,0,0 on consecutive cycles.
   - Response: done one cycle after the 8th bit, data_out=64'h0D, busy low after done.
2. Stuffing:
   - Stimulus: start len=8, bits 1,1,1,1,1,1,0,1,0 (7th bit is the stuff bit).
   - Response: data_out=64'h7F, done after the 9th serial bit, stuff_err never set.
3. Stuff error:
   - Stimulus: start len=16, seven consecutive 1s.
   - Response: stuff_err pulses one cycle after the 7th bit, done never asserted, busy=0, data_out=64'h3F.
4. Full width with gaps:
   - Stimulus: start len=0 (→64), 64 bits alternating 1,0 starting with 1, bit_valid deasserted for 3 cycles between every 8 bits.
   - Response: data_out=64'h5555_5555_5555_5555, single done pulse.
5. Reset mid-field:
   - Stimulus: start len=16, 5 bits sent, async reset asserted between clock edges.
   - Response: outputs 0 immediately.
   - Follow-up: new start len=4 with bits 0,0,1,0 gives data_out=64'h4 and done.
6. Restart and clear:
   - Restart stimulus: start len=8, 3 bits sent, start again len=2, bits 1,1.
   - Restart response: data_out=64'h3, exactly one done.
   - Clear stimulus: clear during RECV.
   - Clear response: IDLE, no done.
